fbuf_arbiter: RTL
=================

// Module: fbuf_arbiter
// PURPOSE
//  Single-port framebuffer RAM arbiter and clear sequencer for the Chip-8 video path.
//  Shares one synchronous RAM (1-cycle read latency) between three requesters:
//   - display fetch (read-only): absolute priority, zero-wait.
//   - hardware clear engine (00E0 CLS): sweeps all words to CLEAR_VALUE.
//   - CPU: read/write, req/ack handshake.
//  Sits between the VGA/NTSC display generator's fbuf_addr/fbuf_data pair and the CPU core.
// PARAMETERS
//  ADDR_W      9    framebuffer word address width
//  DATA_W      16   framebuffer word width
//  FB_WORDS    512  words swept by clear; 1..2**ADDR_W
//  CLEAR_VALUE 0    word written by the clear engine
// PORTS
//  clk        in   1       system clock
//  res        in   1       asynchronous active-high reset
//  disp_req   in   1       display owns the RAM port this cycle (high inside playfield)
//  disp_addr  in   ADDR_W  display read address
//  disp_data  out  DATA_W  display read data = ram_rdata (valid cycle after disp_req)
//  cpu_req    in   1       CPU access request; held high until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read; stable while cpu_req high
//  cpu_addr   in   ADDR_W  CPU word address; stable while cpu_req high
//  cpu_wdata  in   DATA_W  CPU write data; stable while cpu_req high
//  cpu_ack    out  1       1-cycle completion pulse
//  cpu_rdata  out  DATA_W  registered read data; valid with cpu_ack, held until next read
//  clr_start  in   1       1-cycle pulse: start (or restart) a full clear
//  clr_busy   out  1       high from cycle after clr_start until clear finishes
//  clr_done   out  1       1-cycle pulse after last clear write
//  ram_addr   out  ADDR_W  RAM address
//  ram_we     out  1       RAM write enable
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, 1-cycle latency
// BEHAVIOUR
//  Reset: FSM=IDLE; cpu_ack, clr_busy, clr_done, ram_we = 0; cpu_rdata, clr_addr = 0.
//  Port mux (combinational), per cycle:
//   - disp_req=1: ram_addr=disp_addr, ram_we=0; nobody else granted.
//   - else CLEAR: ram_addr=clr_addr, ram_we=1, ram_wdata=CLEAR_VALUE.
//   - else IDLE with cpu_req=1 and no clear pending: CPU granted this cycle (N);
//     ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
//   - else ram_we=0, ram_addr=disp_addr.
//  FSM states: IDLE, CPU_CAP, CPU_ACK, CLEAR.
//   - IDLE -> CPU_CAP on CPU grant; IDLE -> CLEAR if clear pending (clear beats CPU).
//   - CPU_CAP (N+1): if read, cpu_rdata <= ram_rdata at end of cycle; -> CPU_ACK.
//   - CPU_ACK (N+2): cpu_ack=1; -> CLEAR if clear pending else IDLE.
//     cpu_req sampled in CPU_ACK is ignored; a new request is granted no earlier than IDLE.
//   - CLEAR: clr_addr advances only on cycles the clear write is issued (disp_req=0).
//     After the write to FB_WORDS-1: clr_addr<=0, clr_done pulses next cycle, -> IDLE.
//  CPU latency: grant to ack = 2 cycles; writes are committed in cycle N, ack uniform at N+2.
//  Display may take CPU_CAP/CPU_ACK cycles freely; the CPU read result is unaffected (1-cycle RAM latency).
//  clr_start latches a pending flag; clr_busy=1 while pending or in CLEAR.
//  clr_start during CLEAR: clr_addr restarts at 0; no clr_done for the aborted sweep.
//  clr_start during CPU_CAP/CPU_ACK: CPU transaction completes, then CLEAR.
//  clr_start and cpu_req together in IDLE: clear first; CPU waits (cpu_req kept high).
//  Display starvation of CPU/clear during active lines is by design; no timeout.
//  Async reset mid-clear or mid-CPU access: abort; no ack/done issued; RAM content partial.
//  Unstalled clear takes exactly FB_WORDS write cycles.
// STRUCTURE
//  Shared package chip8_video_pkg:
//   - FB_ADDR_W, FB_DATA_W, FB_WORDS constants.
//   - arb_state_t enum {IDLE, CPU_CAP, CPU_ACK, CLEAR}.
//  One sub-module fbuf_clear_seq: address counter + pending/busy/done flags, advance input.
//  The arbiter holds the FSM and port mux.
// TESTING
//  1. Reset mid-CLEAR at clr_addr=100 -> all outputs at reset values; next clr_start sweeps from 0.
//  2. CPU write 0xA5A5 @0x010, then read @0x010, disp_req=0
//     -> ack 2 cycles after each grant; cpu_rdata=0xA5A5.
//  3. disp_req held high 20 cycles with cpu_req pending
//     -> no CPU grant, ram_addr tracks disp_addr; grant in first cycle disp_req=0.
//  4. clr_start, disp_req=0 -> 512 writes of 0 to 0..511;
//     clr_done pulses once; clr_busy low after; CPU read @511 returns 0.
//  5. Clear with disp_req toggling 1/0 -> no address skipped or repeated; completes in 1024 cycles.
//  6. clr_start and cpu_req same cycle in IDLE -> clear completes first;
//     CPU write then acked; its data survives.

Source files
------------

// File: rtl/chip8_video_pkg.sv
// Shared constants and types for the Chip-8 video path.
// The framebuffer arbiter, the display generator and the CPU core all import this package.
package chip8_video_pkg;

    localparam int FB_ADDR_W = 9;
    localparam int FB_DATA_W = 16;
    localparam int FB_WORDS  = 512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_CAP = 2'd1,
        CPU_ACK = 2'd2,
        CLEAR   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fbuf_clear_seq.sv
// Clear-sweep address counter with pending/busy/done bookkeeping.
// The arbiter owns the RAM port; it tells this block when a clear write was actually issued.
module fbuf_clear_seq
    import chip8_video_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int FB_WORDS = chip8_video_pkg::FB_WORDS
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              take,
    input  logic              in_clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              pending,
    output logic              clr_last,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    // A restart arriving on the final write wins: the sweep continues from 0 without a done pulse.
    assign clr_last = advance && (clr_addr == LAST_ADDR) && !start;
    assign clr_busy = pending | in_clear;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            clr_addr <= '0;
            pending  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= clr_last;

            // A start while sweeping (or while entering the sweep) only rewinds the address.
            if (start && !in_clear && !take)
                pending <= 1'b1;
            else if (take)
                pending <= 1'b0;

            if (start || clr_last)
                clr_addr <= '0;
            else if (advance)
                clr_addr <= clr_addr + 1'b1;
        end
    end

endmodule

// File: rtl/fbuf_arbiter.sv
// Single-port framebuffer RAM arbiter: display fetch (absolute priority), clear engine, CPU.
// The RAM has a 1-cycle read latency; CPU accesses are acked uniformly two cycles after grant.
module fbuf_arbiter
    import chip8_video_pkg::*;
#(
    parameter int               ADDR_W      = FB_ADDR_W,
    parameter int               DATA_W      = FB_DATA_W,
    parameter int               FB_WORDS    = chip8_video_pkg::FB_WORDS,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state;
    logic              cap_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_pending;
    logic              clr_last;
    logic              clr_pend;
    logic              cpu_grant;
    logic              clr_advance;
    logic              clr_take;

    // A clr_start in the same cycle already counts as pending, so it beats a simultaneous CPU request.
    assign clr_pend    = clr_pending | clr_start;
    assign cpu_grant   = (state == IDLE) && !disp_req && cpu_req && !clr_pend;
    assign clr_advance = (state == CLEAR) && !disp_req;
    assign clr_take    = clr_pend && ((state == IDLE) || (state == CPU_ACK));
    assign disp_data   = ram_rdata;

    fbuf_clear_seq #(
        .ADDR_W   (ADDR_W),
        .FB_WORDS (FB_WORDS)
    ) u_clear_seq (
        .clk      (clk),
        .res      (res),
        .start    (clr_start),
        .take     (clr_take),
        .in_clear (state == CLEAR),
        .advance  (clr_advance),
        .clr_addr (clr_addr),
        .pending  (clr_pending),
        .clr_last (clr_last),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always_comb begin
        ram_addr  = disp_addr;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        if (disp_req) begin
            ram_addr = disp_addr;
        end else if (state == CLEAR) begin
            ram_addr  = clr_addr;
            ram_we    = 1'b1;
            ram_wdata = CLEAR_VALUE;
        end else if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        state <= CLEAR;
                    end else if (cpu_grant) begin
                        state  <= CPU_CAP;
                        cap_we <= cpu_we;
                    end
                end
                CPU_CAP: begin
                    // The display may own the port now; the CPU read data was addressed last cycle.
                    if (!cap_we)
                        cpu_rdata <= ram_rdata;
                    cpu_ack <= 1'b1;
                    state   <= CPU_ACK;
                end
                CPU_ACK: begin
                    state <= clr_pend ? CLEAR : IDLE;
                end
                CLEAR: begin
                    if (clr_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
